// File: rtl/serial_shift_transmitter.sv
// rtl/serial_shift_transmitter.sv - parallel-to-serial LSB-first transmitter
// Each bit is held for BIT_PERIOD clocks, with a strobe on the last clock of every bit.
module serial_shift_transmitter #(
  parameter int WIDTH      = 8,
  parameter int BIT_PERIOD = 4194304
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_enable,
  output logic             serial_strobe,
  output logic             done
);

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic [PW-1:0]    prescaler, prescaler_next;
  logic             done_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      prescaler <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      prescaler <= prescaler_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt;
    prescaler_next = prescaler;
    done_next      = 1'b0;
    data_ready     = 1'b0;
    serial_enable  = 1'b0;
    serial_out     = 1'b0;
    serial_strobe  = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          shift_next     = data_in;
          bit_cnt_next   = CNT_LOAD;
          prescaler_next = '0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        serial_enable = 1'b1;
        serial_out    = shift_reg[0];
        serial_strobe = (prescaler == PRE_LAST);
        if (serial_strobe) begin
          prescaler_next = '0;
          // Counter reaching zero on a strobe means the last bit has just been sampled.
          if (bit_cnt != '0) begin
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt - CW'(1);
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          prescaler_next = prescaler + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_shift_transmitter.sv
// tb/tb_serial_shift_transmitter.sv - directed scoreboard bench for serial_shift_transmitter
module tb_serial_shift_transmitter;

  localparam int BP = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, serial_out, serial_enable, serial_strobe, done;

  logic [0:0] d1_data;
  logic       d1_valid;
  logic       d1_ready, d1_out, d1_enable, d1_strobe, d1_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic ser;
    logic stb;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  serial_shift_transmitter #(.WIDTH(8), .BIT_PERIOD(BP)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .serial_out(serial_out), .serial_enable(serial_enable),
    .serial_strobe(serial_strobe), .done(done)
  );

  serial_shift_transmitter #(.WIDTH(1), .BIT_PERIOD(1)) dut_min (
    .clock(clock), .reset(reset), .data_in(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .serial_out(d1_out), .serial_enable(d1_enable),
    .serial_strobe(d1_strobe), .done(d1_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < BP; p++) begin
        e.ser = d[k];
        e.stb = (p == BP - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Compares the current cycle then advances; returns at the negedge after n items.
  task automatic drain(input int n, input bit wiggle);
    exp_t e;
    for (int i = 0; i < n && exp_q.size() != 0; i++) begin
      e = exp_q.pop_front();
      check("frame_enable", serial_enable, 1);
      check("frame_out", serial_out, e.ser);
      check("frame_strobe", serial_strobe, e.stb);
      check("frame_ready", data_ready, 0);
      check("frame_done", done, 0);
      if (wiggle) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in    = 8'($urandom);
      end
      @(negedge clock);
    end
    if (wiggle) data_valid = 1'b0;
  endtask

  task automatic check_done_cycle(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_ready"}, data_ready, 1);
    check({tag, "_enable"}, serial_enable, 0);
    check({tag, "_out"}, serial_out, 0);
  endtask

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = '0; d1_valid = 1'b0; d1_data = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", data_ready, 1);
    check("rst_enable", serial_enable, 0);
    check("rst_out", serial_out, 0);
    check("rst_strobe", serial_strobe, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single frame 8'hA5
    data_valid = 1'b1; data_in = 8'hA5;
    check("a5_accept_ready", data_ready, 1);
    push_frame(8'hA5);
    @(negedge clock);
    data_valid = 1'b0;
    drain(8 * BP, 1'b0);
    check_done_cycle("a5");
    @(negedge clock);
    check("a5_post_done", done, 0);

    // Back-to-back 8'h01 then 8'h80 with data_valid held
    data_valid = 1'b1; data_in = 8'h01;
    push_frame(8'h01);
    @(negedge clock);
    data_in = 8'h80;
    drain(8 * BP, 1'b0);
    check_done_cycle("b2b1");
    push_frame(8'h80);
    @(negedge clock);
    data_valid = 1'b0;
    drain(8 * BP, 1'b0);
    check_done_cycle("b2b2");
    @(negedge clock);

    // Inputs wiggled during SHIFT must not disturb the frame
    data_valid = 1'b1; data_in = 8'h3C;
    push_frame(8'h3C);
    @(negedge clock);
    drain(8 * BP, 1'b1);
    check_done_cycle("ign");
    @(negedge clock);

    // Reset at cycle N+10 of a frame
    data_valid = 1'b1; data_in = 8'hFF;
    push_frame(8'hFF);
    @(negedge clock);
    data_valid = 1'b0;
    drain(9, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_enable", serial_enable, 0);
    check("mid_rst_out", serial_out, 0);
    check("mid_rst_ready", data_ready, 1);
    for (int i = 0; i < 30; i++) begin
      check("mid_rst_no_done", done, 0);
      check("mid_rst_idle", serial_enable, 0);
      @(negedge clock);
    end

    // Simultaneous reset and accept
    reset = 1'b1; data_valid = 1'b1; data_in = 8'hC3;
    @(negedge clock);
    reset = 1'b0; data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst_acc_enable", serial_enable, 0);
      check("rst_acc_ready", data_ready, 1);
      check("rst_acc_done", done, 0);
      @(negedge clock);
    end

    // Minimum configuration WIDTH=1, BIT_PERIOD=1
    d1_valid = 1'b1; d1_data = 1'b1;
    check("min_accept_ready", d1_ready, 1);
    @(negedge clock);
    d1_valid = 1'b0;
    check("min_out", d1_out, 1);
    check("min_enable", d1_enable, 1);
    check("min_strobe", d1_strobe, 1);
    check("min_ready", d1_ready, 0);
    check("min_done_early", d1_done, 0);
    @(negedge clock);
    check("min_done", d1_done, 1);
    check("min_ready_after", d1_ready, 1);
    check("min_enable_after", d1_enable, 0);
    @(negedge clock);
    check("min_done_once", d1_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_shift_transmitter.md
SERIAL_SHIFT_TRANSMITTER -- requirements
Module: serial_shift_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per frame (legal: WIDTH >= 1).
REQ-002 The block SHALL have parameter BIT_PERIOD, default 4194304, meaning clock cycles per serial bit (2^22, about 0.35 s at 12 MHz; legal: BIT_PERIOD >= 1).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port data_valid, input, 1 bit: data_in is offered.
REQ-007 The block SHALL have port data_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port serial_out, output, 1 bit: serial data line, LSB first.
REQ-009 The block SHALL have port serial_enable, output, 1 bit: high while a frame is on serial_out.
REQ-010 The block SHALL have port serial_strobe, output, 1 bit: one-cycle pulse on the last cycle of each bit period (receiver sample point).
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after a frame completes.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 IDLE behaviour SHALL be:
- data_ready = 1; serial_enable = 0; serial_out = 0; serial_strobe = 0.
REQ-014 Accept and load SHALL work as follows:
- Accept occurs in the cycle where data_valid & data_ready are both 1.
- In that cycle: load data_in into a WIDTH-bit shift register, set the bit counter to WIDTH-1, clear the prescaler to 0, and go to SHIFT.
REQ-015 data_in SHALL be sampled only on accept; data_in and data_valid SHALL be ignored in SHIFT.
REQ-016 SHIFT behaviour SHALL be:
- data_ready = 0; serial_enable = 1; serial_out = shift register bit 0.
REQ-017 The prescaler SHALL count 0..BIT_PERIOD-1 in SHIFT and wrap to 0.
- serial_strobe = 1 exactly when the prescaler equals BIT_PERIOD-1.
REQ-018 On each serial_strobe with bit counter != 0:
- Shift the register right by one, filling the MSB with 0.
- Decrement the bit counter.
REQ-019 On serial_strobe with bit counter == 0, the next state SHALL be IDLE.
REQ-020 done SHALL be 1 for exactly the first IDLE cycle following SHIFT, and 0 otherwise.
REQ-021 Timing for an accept at cycle N SHALL be:
- Bit k appears on serial_out during cycles N+1+k*BIT_PERIOD .. N+(k+1)*BIT_PERIOD.
- The frame lasts WIDTH*BIT_PERIOD cycles.
- done and data_ready are high at cycle N+1+WIDTH*BIT_PERIOD.
REQ-022 Back-to-back frames SHALL be supported:
- An accept in the done cycle starts the next frame immediately.
- There are no idle bit periods between frames beyond that single IDLE cycle.
REQ-023 BIT_PERIOD = 1 SHALL be legal: serial_strobe is high every SHIFT cycle and each bit lasts one cycle.
REQ-024 WIDTH = 1 SHALL be legal: the frame is a single bit period.
REQ-025 The prescaler SHALL be sized as clog2(BIT_PERIOD) bits (minimum 1); the bit counter SHALL be sized as clog2(WIDTH) bits (minimum 1).
- Neither counter may overflow within a frame.
REQ-026 Outputs SHALL be registered or decoded from registered state only; no combinational path from data_valid to any output except data_ready's dependence on state.

Reset
REQ-027 On reset = 1 at a clock edge, the next cycle SHALL show:
- State IDLE; shift register, bit counter and prescaler all 0.
- data_ready = 1; serial_out = 0; serial_enable = 0; serial_strobe = 0; done = 0.
REQ-028 Reset SHALL override every other input, including a simultaneous accept.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-030 The first accept after reset is released SHALL start a frame normally.

Verification (WIDTH=8, BIT_PERIOD=3 unless noted)
REQ-031 Single frame SHALL be covered:
- Stimulus: accept data_in=8'hA5 at cycle N.
- Required: serial_out = 1,0,1,0,0,1,0,1, each held 3 cycles from N+1; serial_strobe at N+3, N+6, ..., N+24; done and data_ready high at N+25.
REQ-032 Back-to-back SHALL be covered:
- Stimulus: hold data_valid high with 8'h01 then 8'h80.
- Required: second accept in the done cycle; second frame serial_out is 0 for 21 cycles, then 1 for 3 cycles.
REQ-033 Ignored input SHALL be covered:
- Stimulus: during SHIFT, toggle data_valid and change data_in.
- Required: data_ready stays 0; the transmitted bits equal the originally accepted word.
REQ-034 Reset mid-frame SHALL be covered:
- Stimulus: assert reset at cycle N+10 of a frame.
- Required: at N+11, serial_enable=0, serial_out=0, data_ready=1; no done pulse follows.
REQ-035 Minimum period SHALL be covered:
- Stimulus: BIT_PERIOD=1, WIDTH=1, accept 1'b1 at N.
- Required: serial_out=1, serial_enable=1, serial_strobe=1 at N+1; done=1 at N+2.
REQ-036 Simultaneous reset and accept SHALL be covered:
- Stimulus: reset=1 and data_valid=1 in the same cycle.
- Required: the block stays IDLE and no frame is started.
